// File: rtl/craps_round_ctrl.sv
// Craps round sequencer: conditions the enter button, strobes roll/sp, settles outcomes and keeps the bankroll.
// Optional enter debounce filter is built when CRAPS_DEBOUNCE_EN is defined.
module craps_round_ctrl #(
  parameter int BANK_W    = 8,
  parameter int BANK_INIT = 100,
  parameter int BET       = 10,
  parameter int SETTLE    = 2,
  parameter int DB_CYCLES = 4
) (
  input  logic              i_clk_main,
  input  logic              i_reset,
  input  logic              i_enter,
  input  logic              i_new_game,
  input  logic              i_natural,
  input  logic              i_craps,
  input  logic              i_seven_out,
  input  logic              i_eq,
  output logic              o_roll,
  output logic              o_sp,
  output logic              o_win,
  output logic              o_lose,
  output logic [BANK_W-1:0] o_bankroll,
  output logic              o_game_over,
  output logic [2:0]        o_state_out
);

  localparam int CNT_W = (SETTLE < 2) ? 1 : $clog2(SETTLE + 1);
  localparam logic [BANK_W-1:0] L_BET  = BANK_W'(BET);
  localparam logic [BANK_W-1:0] L_INIT = BANK_W'(BANK_INIT);

  if (SETTLE < 1 || DB_CYCLES < 1) begin : g_bad_cfg
    $error("craps_round_ctrl: SETTLE and DB_CYCLES must be >= 1");
  end

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_CO_WAIT = 3'd1,
    S_POINT   = 3'd2,
    S_PT_WAIT = 3'd3,
    S_RESULT  = 3'd4,
    S_OVER    = 3'd5
  } state_t;

  // ---------------- enter conditioning ----------------
  logic r_sync1, r_sync2, r_lvl_d;
  logic w_lvl, w_go;

  always_ff @(posedge i_clk_main or posedge i_reset) begin
    if (i_reset) begin
      r_sync1 <= 1'b0;
      r_sync2 <= 1'b0;
      r_lvl_d <= 1'b0;
    end else begin
      r_sync1 <= i_enter;
      r_sync2 <= r_sync1;
      r_lvl_d <= w_lvl;
    end
  end

`ifdef CRAPS_DEBOUNCE_EN
  localparam int DB_W = (DB_CYCLES < 2) ? 1 : $clog2(DB_CYCLES + 1);
  logic            r_db_lvl;
  logic [DB_W-1:0] r_db_cnt;

  // Filtered level flips only after DB_CYCLES consecutive samples disagree with it.
  always_ff @(posedge i_clk_main or posedge i_reset) begin
    if (i_reset) begin
      r_db_lvl <= 1'b0;
      r_db_cnt <= '0;
    end else if (r_sync2 == r_db_lvl) begin
      r_db_cnt <= '0;
    end else if (r_db_cnt == DB_W'(DB_CYCLES - 1)) begin
      r_db_lvl <= r_sync2;
      r_db_cnt <= '0;
    end else begin
      r_db_cnt <= r_db_cnt + 1'b1;
    end
  end

  assign w_lvl = r_db_lvl;
`else
  assign w_lvl = r_sync2;
`endif

  assign w_go = w_lvl & ~r_lvl_d;

  // ---------------- round FSM ----------------
  state_t             r_state, w_state_nxt;
  logic [CNT_W-1:0]   r_cnt, w_cnt_nxt;
  logic               r_roll, r_sp, r_win, r_lose;
  logic               w_roll_nxt, w_sp_nxt, w_win_nxt, w_lose_nxt;
  logic [BANK_W-1:0]  r_bank, w_bank_nxt;
  logic [BANK_W:0]    w_sum;
  logic [BANK_W-1:0]  w_bank_add, w_bank_sub;
  logic               w_broke, w_expire;

  assign w_sum      = {1'b0, r_bank} + {1'b0, L_BET};
  assign w_bank_add = w_sum[BANK_W] ? '1 : w_sum[BANK_W-1:0];
  assign w_bank_sub = (r_bank >= L_BET) ? (r_bank - L_BET) : '0;
  assign w_broke    = (r_bank < L_BET);
  assign w_expire   = (r_cnt <= CNT_W'(1));

  always_ff @(posedge i_clk_main or posedge i_reset) begin
    if (i_reset) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
      r_roll  <= 1'b0;
      r_sp    <= 1'b0;
      r_win   <= 1'b0;
      r_lose  <= 1'b0;
      r_bank  <= L_INIT;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_roll  <= w_roll_nxt;
      r_sp    <= w_sp_nxt;
      r_win   <= w_win_nxt;
      r_lose  <= w_lose_nxt;
      r_bank  <= w_bank_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_roll_nxt  = 1'b0;
    w_sp_nxt    = 1'b0;
    w_win_nxt   = r_win;
    w_lose_nxt  = r_lose;
    w_bank_nxt  = r_bank;
    if (i_new_game) begin
      w_state_nxt = S_IDLE;
      w_cnt_nxt   = '0;
      w_win_nxt   = 1'b0;
      w_lose_nxt  = 1'b0;
      w_bank_nxt  = L_INIT;
    end else begin
      case (r_state)
        S_IDLE, S_RESULT: begin
          if (w_go) begin
            if (w_broke) begin
              w_state_nxt = S_OVER;
            end else begin
              w_roll_nxt  = 1'b1;
              w_win_nxt   = 1'b0;
              w_lose_nxt  = 1'b0;
              w_cnt_nxt   = CNT_W'(SETTLE);
              w_state_nxt = S_CO_WAIT;
            end
          end
        end
        S_CO_WAIT: begin
          if (!w_expire) begin
            w_cnt_nxt = r_cnt - 1'b1;
          end else if (i_craps) begin
            w_lose_nxt  = 1'b1;
            w_bank_nxt  = w_bank_sub;
            w_state_nxt = S_RESULT;
          end else if (i_natural) begin
            w_win_nxt   = 1'b1;
            w_bank_nxt  = w_bank_add;
            w_state_nxt = S_RESULT;
          end else begin
            w_sp_nxt    = 1'b1;
            w_state_nxt = S_POINT;
          end
        end
        S_POINT: begin
          if (w_go) begin
            w_roll_nxt  = 1'b1;
            w_cnt_nxt   = CNT_W'(SETTLE);
            w_state_nxt = S_PT_WAIT;
          end
        end
        S_PT_WAIT: begin
          if (!w_expire) begin
            w_cnt_nxt = r_cnt - 1'b1;
          end else if (i_eq) begin
            w_win_nxt   = 1'b1;
            w_bank_nxt  = w_bank_add;
            w_state_nxt = S_RESULT;
          end else if (i_seven_out) begin
            w_lose_nxt  = 1'b1;
            w_bank_nxt  = w_bank_sub;
            w_state_nxt = S_RESULT;
          end else begin
            w_state_nxt = S_POINT;
          end
        end
        S_OVER: w_state_nxt = S_OVER;
        default: w_state_nxt = S_IDLE;
      endcase
    end
  end

  assign o_roll      = r_roll;
  assign o_sp        = r_sp;
  assign o_win       = r_win;
  assign o_lose      = r_lose;
  assign o_bankroll  = r_bank;
  assign o_game_over = w_broke;
  assign o_state_out = r_state;

endmodule

// File: tb/tb_craps_round_ctrl.sv
// Bench for craps_round_ctrl: scoreboard of expected round results, default and saturating instances.
module tb_craps_round_ctrl;

`ifdef CRAPS_DEBOUNCE_EN
  localparam int EXTRA = 4;
  localparam int HOLD  = 10;
`else
  localparam int EXTRA = 0;
  localparam int HOLD  = 1;
`endif

  logic clk = 1'b0, reset = 1'b1;
  logic enter = 1'b0, new_game = 1'b0, enter2 = 1'b0, ng2 = 1'b0;
  logic nat = 1'b0, crp = 1'b0, sev = 1'b0, eqf = 1'b0;
  logic roll, sp, win, lose, gover;
  logic [7:0] bank;
  logic [2:0] st;
  logic roll2, sp2, win2, lose2, gover2;
  logic [7:0] bank2;
  logic [2:0] st2;

  craps_round_ctrl dut (
    .i_clk_main(clk), .i_reset(reset), .i_enter(enter), .i_new_game(new_game),
    .i_natural(nat), .i_craps(crp), .i_seven_out(sev), .i_eq(eqf),
    .o_roll(roll), .o_sp(sp), .o_win(win), .o_lose(lose),
    .o_bankroll(bank), .o_game_over(gover), .o_state_out(st));

  craps_round_ctrl #(.BANK_INIT(250)) dut2 (
    .i_clk_main(clk), .i_reset(reset), .i_enter(enter2), .i_new_game(ng2),
    .i_natural(nat), .i_craps(crp), .i_seven_out(sev), .i_eq(eqf),
    .o_roll(roll2), .o_sp(sp2), .o_win(win2), .o_lose(lose2),
    .o_bankroll(bank2), .o_game_over(gover2), .o_state_out(st2));

  always #5 clk = ~clk;

  int n_tests = 0, n_fail = 0;
  int n_roll = 0, n_sp = 0;

  always @(posedge clk) begin
    if (roll) n_roll <= n_roll + 1;
    if (sp)   n_sp   <= n_sp + 1;
  end

  typedef struct packed {
    logic       win;
    logic       lose;
    logic [7:0] bank;
    logic [2:0] st;
    logic [7:0] rolls;
    logic [7:0] sps;
  } exp_t;

  exp_t exp_q[$];
  logic [7:0] m_bank = 8'd100;
  int r0, s0;

  function automatic logic [7:0] m_add(input logic [7:0] b);
    int s = int'(b) + 10;
    return (s > 255) ? 8'd255 : 8'(s);
  endfunction

  function automatic logic [7:0] m_sub(input logic [7:0] b);
    return (b >= 8'd10) ? b - 8'd10 : 8'd0;
  endfunction

  task automatic push(input logic w, input logic l, input logic [2:0] s, input int rl, input int sc);
    exp_t e;
    e.win = w; e.lose = l; e.bank = m_bank; e.st = s; e.rolls = 8'(rl); e.sps = 8'(sc);
    exp_q.push_back(e);
    r0 = n_roll; s0 = n_sp;
  endtask

  task automatic press();
    @(negedge clk); enter = 1'b1;
    repeat (HOLD) @(negedge clk);
    enter = 1'b0;
    repeat (8 + EXTRA) @(negedge clk);
  endtask

  function automatic exp_t observed();
    exp_t o;
    o.win = win; o.lose = lose; o.bank = bank; o.st = st;
    o.rolls = 8'(n_roll - r0); o.sps = 8'(n_sp - s0);
    return o;
  endfunction

  task automatic test_reset();
    repeat (3) @(negedge clk);
    n_tests++;
    if ({st, roll, sp, win, lose, bank, gover} !== {3'd0, 4'b0000, 8'd100, 1'b0}) begin
      n_fail++;
      $display("FAIL reset: got st=%0d roll=%b sp=%b win=%b lose=%b bank=%0d go=%b, want 0 0 0 0 0 100 0",
               st, roll, sp, win, lose, bank, gover);
    end
    n_tests++;
    if (bank2 !== 8'd250) begin
      n_fail++; $display("FAIL reset2_bank: got %0d want 250", bank2);
    end
    reset = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_natural();
    exp_t e, o;
    nat = 1'b1;
    m_bank = m_add(m_bank);
    push(1'b1, 1'b0, 3'd4, 1, 0);
    press();
    e = exp_q.pop_front(); o = observed();
    n_tests++;
    if (o !== e) begin
      n_fail++; $display("FAIL natural: got %h want %h", o, e);
    end
    nat = 1'b0;
  endtask

  task automatic test_craps();
    exp_t e, o;
    crp = 1'b1;
    for (int i = 0; i < 11; i++) begin
      m_bank = m_sub(m_bank);
      push(1'b0, 1'b1, 3'd4, 1, 0);
      press();
      e = exp_q.pop_front(); o = observed();
      n_tests++;
      if (o !== e) begin
        n_fail++; $display("FAIL craps_round%0d: got %h want %h", i, o, e);
      end
    end
    push(1'b0, 1'b1, 3'd5, 0, 0);
    press();
    e = exp_q.pop_front(); o = observed();
    n_tests++;
    if (o !== e || gover !== 1'b1) begin
      n_fail++; $display("FAIL game_over: got %h go=%b want %h go=1", o, gover, e);
    end
    crp = 1'b0;
    // OVER must ignore further presses
    push(1'b0, 1'b1, 3'd5, 0, 0);
    press();
    e = exp_q.pop_front(); o = observed();
    n_tests++;
    if (o !== e) begin
      n_fail++; $display("FAIL over_sticky: got %h want %h", o, e);
    end
    @(negedge clk); new_game = 1'b1;
    @(negedge clk); new_game = 1'b0;
    m_bank = 8'd100;
    n_tests++;
    if ({st, win, lose, bank, gover} !== {3'd0, 2'b00, 8'd100, 1'b0}) begin
      n_fail++;
      $display("FAIL new_game: got st=%0d win=%b lose=%b bank=%0d go=%b want 0 0 0 100 0",
               st, win, lose, bank, gover);
    end
  endtask

  // Each row: flags {nat,crp,sev,eq}, expected {win,lose}, state, bank delta (-1/0/+1), sp pulses
  task automatic test_point();
    logic [3:0] flags [8] = '{4'b0000, 4'b0010, 4'b0000, 4'b0011, 4'b1100, 4'b0000, 4'b0000, 4'b0001};
    logic [1:0] wl    [8] = '{2'b00, 2'b01, 2'b00, 2'b10, 2'b01, 2'b00, 2'b00, 2'b10};
    logic [2:0] sx    [8] = '{3'd2, 3'd4, 3'd2, 3'd4, 3'd4, 3'd2, 3'd2, 3'd4};
    int         dl    [8] = '{0, -1, 0, 1, -1, 0, 0, 1};
    int         spn   [8] = '{1, 0, 1, 0, 0, 1, 0, 0};
    exp_t e, o;
    for (int i = 0; i < 8; i++) begin
      {nat, crp, sev, eqf} = flags[i];
      if (dl[i] > 0) m_bank = m_add(m_bank);
      else if (dl[i] < 0) m_bank = m_sub(m_bank);
      push(wl[i][1], wl[i][0], sx[i], 1, spn[i]);
      press();
      e = exp_q.pop_front(); o = observed();
      n_tests++;
      if (o !== e) begin
        n_fail++; $display("FAIL point_step%0d: got %h want %h", i, o, e);
      end
    end
    {nat, crp, sev, eqf} = 4'b0000;
  endtask

  task automatic test_latency();
    logic exp_roll;
    crp = 1'b1;
    r0 = n_roll;
    @(negedge clk); enter = 1'b1;
    for (int c = 1; c <= 5 + EXTRA; c++) begin
      @(negedge clk);
      if (c == HOLD) enter = 1'b0;
      exp_roll = (c == 3 + EXTRA);
      n_tests++;
      if (roll !== exp_roll) begin
        n_fail++; $display("FAIL latency_c%0d: roll=%b want %b", c, roll, exp_roll);
      end
    end
    m_bank = m_sub(m_bank);
    n_tests++;
    if ({st, lose, bank} !== {3'd4, 1'b1, m_bank} || n_roll - r0 != 1) begin
      n_fail++; $display("FAIL latency_result: st=%0d lose=%b bank=%0d rolls=%0d want 4 1 %0d 1",
                         st, lose, bank, n_roll - r0, m_bank);
    end
    enter = 1'b0;
    repeat (HOLD + 2) @(negedge clk);
    crp = 1'b0;
  endtask

`ifdef CRAPS_DEBOUNCE_EN
  task automatic test_glitch();
    r0 = n_roll;
    @(negedge clk); enter = 1'b1;
    repeat (2) @(negedge clk);
    enter = 1'b0;
    repeat (15) @(negedge clk);
    n_tests++;
    if (n_roll - r0 != 0 || st !== 3'd4) begin
      n_fail++; $display("FAIL glitch: rolls=%0d st=%0d want 0 4", n_roll - r0, st);
    end
  endtask
`else
  task automatic double_press();
    @(negedge clk); enter = 1'b1;
    @(negedge clk); enter = 1'b0;
    @(negedge clk); enter = 1'b1;
    @(negedge clk); enter = 1'b0;
    repeat (8) @(negedge clk);
  endtask

  task automatic test_ignored_go();
    exp_t e, o;
    nat = 1'b1;
    m_bank = m_add(m_bank);
    push(1'b1, 1'b0, 3'd4, 1, 0);
    double_press();
    e = exp_q.pop_front(); o = observed();
    n_tests++;
    if (o !== e) begin
      n_fail++; $display("FAIL ignore_co_wait: got %h want %h", o, e);
    end
    nat = 1'b0;
    push(1'b0, 1'b0, 3'd2, 1, 1);
    press();
    e = exp_q.pop_front(); o = observed();
    n_tests++;
    if (o !== e) begin
      n_fail++; $display("FAIL ignore_to_point: got %h want %h", o, e);
    end
    eqf = 1'b1;
    m_bank = m_add(m_bank);
    push(1'b1, 1'b0, 3'd4, 1, 0);
    double_press();
    e = exp_q.pop_front(); o = observed();
    n_tests++;
    if (o !== e) begin
      n_fail++; $display("FAIL ignore_pt_wait: got %h want %h", o, e);
    end
    eqf = 1'b0;
  endtask
`endif

  task automatic test_saturate();
    nat = 1'b1;
    @(negedge clk); enter2 = 1'b1;
    repeat (HOLD) @(negedge clk);
    enter2 = 1'b0;
    repeat (8 + EXTRA) @(negedge clk);
    n_tests++;
    if ({bank2, win2, lose2, st2} !== {8'd255, 2'b10, 3'd4}) begin
      n_fail++; $display("FAIL saturate: bank=%0d win=%b lose=%b st=%0d want 255 1 0 4",
                         bank2, win2, lose2, st2);
    end
    nat = 1'b0;
    @(negedge clk); enter2 = 1'b1;
    repeat (HOLD) @(negedge clk);
    enter2 = 1'b0;
    repeat (8 + EXTRA) @(negedge clk);
    n_tests++;
    if (st2 !== 3'd2) begin
      n_fail++; $display("FAIL sat_point: st=%0d want 2", st2);
    end
    @(negedge clk); enter2 = 1'b1;
    for (int c = 1; c <= 3 + EXTRA; c++) begin
      @(negedge clk);
      if (c == HOLD) enter2 = 1'b0;
    end
    n_tests++;
    if (st2 !== 3'd3) begin
      n_fail++; $display("FAIL sat_pt_wait: st=%0d want 3", st2);
    end
    ng2 = 1'b1;
    @(negedge clk); ng2 = 1'b0;
    n_tests++;
    if ({bank2, win2, lose2, st2, roll2} !== {8'd250, 2'b00, 3'd0, 1'b0}) begin
      n_fail++; $display("FAIL new_game_mid: bank=%0d win=%b lose=%b st=%0d roll=%b want 250 0 0 0 0",
                         bank2, win2, lose2, st2, roll2);
    end
    enter2 = 1'b0;
    repeat (HOLD + 4) @(negedge clk);
  endtask

  task automatic test_async_reset();
    nat = 1'b1;
    @(negedge clk); enter = 1'b1;
    for (int c = 1; c <= 3 + EXTRA; c++) begin
      @(negedge clk);
      if (c == HOLD) enter = 1'b0;
    end
    n_tests++;
    if (st !== 3'd1) begin
      n_fail++; $display("FAIL areset_pre: st=%0d want 1", st);
    end
    #2 reset = 1'b1;
    #1;
    n_tests++;
    if ({st, bank, win, lose, roll} !== {3'd0, 8'd100, 3'b000}) begin
      n_fail++; $display("FAIL areset: st=%0d bank=%0d win=%b lose=%b roll=%b want 0 100 0 0 0",
                         st, bank, win, lose, roll);
    end
    enter = 1'b0;
    nat = 1'b0;
    @(negedge clk); reset = 1'b0;
    m_bank = 8'd100;
  endtask

  initial begin
    test_reset();
    test_natural();
    test_craps();
    test_point();
    test_latency();
`ifdef CRAPS_DEBOUNCE_EN
    test_glitch();
`else
    test_ignored_go();
`endif
    test_saturate();
    test_async_reset();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/craps_round_ctrl.md
# craps_round_ctrl

Round sequencer for the craps dice datapath. It conditions the raw `enter` button and issues single-cycle `roll` and `sp` strobes to the datapath. It evaluates the datapath's outcome flags through the come-out and point phases and keeps a bankroll that changes by a fixed bet per round. It sits between the board push-buttons and the datapath, and its win/lose/bankroll outputs drive the board LEDs and displays.

## Interface
- `BANK_W`, 8: bankroll width in bits.
- `BANK_INIT`, 100: bankroll value after reset or `new_game`.
- `BET`, 10: amount won or lost per round.
- `SETTLE`, 2: cycles waited after a `roll` pulse before the datapath flags are sampled (≥1).
- `DB_CYCLES`, 4: debounce stability length. Used only with `CRAPS_DEBOUNCE_EN`.

- `clk_main`  in  1  system clock.
- `reset`  in  1  asynchronous, active-high reset.
- `enter`  in  1  raw push-button, active-high, asynchronous to `clk_main`.
- `new_game`  in  1  synchronous request to restart the game.
- `natural`, `craps`, `seven_out`, `eq`  in  1 each  datapath outcome flags.
- `roll`  out  1  one-cycle strobe to the datapath to roll the dice.
- `sp`  out  1  one-cycle strobe to the datapath to latch the point.
- `win`, `lose`  out  1 each  result of the last round, held as a level.
- `bankroll`  out  `BANK_W`  current credit.
- `game_over`  out  1  high when `bankroll` < `BET`.
- `state_out`  out  3  current state encoding, for debug.

## Operation
- `enter` passes through a 2-flop synchronizer and then a rising-edge detector, producing `go` (one cycle). `go` pulses that arrive outside IDLE, POINT and RESULT are dropped, not queued.
- States and encodings: IDLE=0, CO_WAIT=1, POINT=2, PT_WAIT=3, RESULT=4, OVER=5. Encodings 6 and 7 return to IDLE on the next edge.
- **IDLE and RESULT** on `go`:
  - If `bankroll` < `BET`: go to OVER.
  - Otherwise: pulse `roll`, clear `win`/`lose`, load the settle counter with `SETTLE`, go to CO_WAIT.
- **CO_WAIT**: count down. On the expiry cycle, sample the flags:
  - `craps`: set `lose`, `bankroll` −= `BET`, go to RESULT.
  - else `natural`: set `win`, `bankroll` += `BET`, go to RESULT.
  - else: pulse `sp`, go to POINT.
  - `craps` takes priority if both flags are high.
- **POINT** on `go`: pulse `roll`, reload the counter, go to PT_WAIT.
- **PT_WAIT**: on expiry:
  - `eq`: win, `bankroll` += `BET`, go to RESULT.
  - else `seven_out`: lose, `bankroll` −= `BET`, go to RESULT.
  - else: go to POINT.
  - `eq` takes priority if both flags are high.
- **OVER**: `game_over`=1. Only `new_game` leaves this state.
- **`new_game`**, high at any clock edge in any state, overrides everything else:
  - `bankroll` = `BANK_INIT`; `win`, `lose`, `roll`, `sp` = 0; state = IDLE.
  - A `go` in the same cycle is ignored.
- **Bankroll arithmetic**: unsigned.
  - Additions saturate at 2^`BANK_W`−1.
  - Subtraction floors at 0. It cannot underflow, because a round only starts when `bankroll` ≥ `BET`.
- `game_over` is combinational on `bankroll` < `BET`.

## Timing
- Reset values: state=IDLE, `roll`=0, `sp`=0, `win`=0, `lose`=0, `bankroll`=`BANK_INIT`, synchronizer and debounce flops 0, counter 0.
- All outputs except `game_over` are registered.
- Let k be the first edge at which `enter` is sampled high, with debounce off. `roll` is high for the single cycle following edge k+2.
- Let r be the edge that asserts `roll`. Flags are sampled at edge r+`SETTLE`. `win`/`lose`/`bankroll` (or `sp`) update at that same edge.
- Per the Operation rules, `win`/`lose` are cleared at the edge that asserts `roll` when leaving IDLE/RESULT, and otherwise hold.
- If `reset` is asserted mid-round, all state is cleared immediately, without waiting for a clock edge.

## Configuration
- `CRAPS_DEBOUNCE_EN`
  - Defined: the synchronized `enter` level is accepted only after `DB_CYCLES` consecutive equal samples, and `go` is the rising edge of that filtered level. This adds `DB_CYCLES` cycles to the `enter`→`roll` latency. Glitches shorter than `DB_CYCLES` cycles produce no `go`.
  - Undefined: `go` is the rising edge of the synchronized level directly.

## Test plan
- Reset, then `enter` pulse with `natural`=1 at sample time → one `roll` pulse; `win`=1, `bankroll`=110, state=RESULT.
- `enter` with `craps`=1 → `lose`=1, `bankroll`=90. Repeat until `bankroll`=0 → the next `enter` gives `game_over`=1, state=OVER, and no `roll`.
- Come-out with neither flag → exactly one `sp` pulse, state=POINT.
  - Next `enter` with `seven_out`=1 → `lose`.
  - Repeat with `eq`=1 instead → `win`.
- `enter` pulses during CO_WAIT and PT_WAIT → no extra `roll` pulses, and the state sequence is unchanged.
- `BANK_INIT`=250, `BET`=10, `BANK_W`=8, natural win → `bankroll`=255 (saturated). `new_game` mid-PT_WAIT → `bankroll`=250, state=IDLE, `win`=`lose`=0.
- With `CRAPS_DEBOUNCE_EN`, a 2-cycle `enter` glitch → no `roll`; a 10-cycle press → exactly one `roll`, on the cycle after edge k+2+`DB_CYCLES`.
